alu_core: RTL and testbench

- Parameterised N-bit integer ALU for the processor datapath; computes one of 16 operations selected by a 4-bit opcode on operands a and b.
- Result and status flags are registered: one clock of latency, updated every cycle, with no enable or handshake.
- Feeds the execute-stage result mux and the branch/compare logic.

---
 rtl/alu_core.sv | 123 ++++++++++++
 tb/tb_alu_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// alu_core: N-bit integer ALU with registered result and status flags.
// One clock of latency and one operation per cycle.
module alu_core #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   operation,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] out,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_PASB = 4'b1011;
    localparam logic [3:0] OP_NOT  = 4'b1100;
    localparam logic [3:0] OP_NEG  = 4'b1101;
    localparam logic [3:0] OP_MIN  = 4'b1110;
    localparam logic [3:0] OP_MAX  = 4'b1111;

    logic [N:0]   add_sum;
    logic [N:0]   sub_sum;
    logic [N:0]   neg_sum;
    logic         lt_s;
    logic         lt_u;

    logic [N-1:0] out_d;
    logic         carry_d;
    logic         overflow_d;

    logic [N-1:0] out_q;
    logic         zero_q;
    logic         negative_q;
    logic         carry_q;
    logic         overflow_q;

    // Shared adders and comparators; SUB and NEG both use a + ~x + 1.
    always_comb begin
        add_sum = {1'b0, a} + {1'b0, b};
        sub_sum = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        neg_sum = {1'b0, {N{1'b0}}} + {1'b0, ~a} + (N+1)'(1);
        lt_s    = $signed(a) < $signed(b);
        lt_u    = a < b;
    end

    // Result and carry/overflow selection by opcode.
    always_comb begin
        out_d      = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        unique case (operation)
            OP_ADD: begin
                out_d      = add_sum[N-1:0];
                carry_d    = add_sum[N];
                overflow_d = (a[N-1] == b[N-1]) &&
                             (add_sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                out_d      = sub_sum[N-1:0];
                carry_d    = sub_sum[N];
                overflow_d = (a[N-1] != b[N-1]) &&
                             (sub_sum[N-1] != a[N-1]);
            end
            OP_AND:  out_d = a & b;
            OP_OR:   out_d = a | b;
            OP_XOR:  out_d = a ^ b;
            OP_SLL:  out_d = a << b;
            OP_SRL:  out_d = a >> b;
            OP_SRA:  out_d = $signed(a) >>> b;
            OP_MUL:  out_d = a * b;
            OP_SLT:  out_d = {{(N-1){1'b0}}, lt_s};
            OP_SLTU: out_d = {{(N-1){1'b0}}, lt_u};
            OP_PASB: out_d = b;
            OP_NOT:  out_d = ~a;
            OP_NEG: begin
                out_d      = neg_sum[N-1:0];
                carry_d    = neg_sum[N];
                overflow_d = a[N-1] && neg_sum[N-1];
            end
            OP_MIN:  out_d = lt_s ? a : b;
            OP_MAX:  out_d = lt_s ? b : a;
            default: out_d = '0;
        endcase
    end

    // Output stage; reset shows a zero result with zero flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            zero_q     <= 1'b1;
            negative_q <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            zero_q     <= (out_d == '0);
            negative_q <= out_d[N-1];
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    assign out      = out_q;
    assign zero     = zero_q;
    assign negative = negative_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed table, pipeline/reset sequences and random
// vectors against an integer reference model of the ALU.
module tb_alu_core;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   operation;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] out;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_core #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operation (operation),
        .a         (a),
        .b         (b),
        .out       (out),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow)
    );

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] eo;
        logic [3:0] ef;
    } vec_t;

    vec_t vt[22];

    // Reference: plain integer arithmetic, returns {out, z, n, c, v}.
    function automatic logic [11:0] model(input logic [3:0] op,
                                          input logic [7:0] ua,
                                          input logic [7:0] ub);
        int ia, ib, sa, sb, r, t;
        logic c, v;
        logic [7:0] res;
        ia = int'(ua);
        ib = int'(ub);
        sa = ua[7] ? ia - 256 : ia;
        sb = ub[7] ? ib - 256 : ib;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            4'd0: begin
                r = ia + ib;
                c = (r > 255);
                t = sa + sb;
                v = (t > 127) || (t < -128);
            end
            4'd1: begin
                r = ia - ib;
                c = (ia >= ib);
                t = sa - sb;
                v = (t > 127) || (t < -128);
            end
            4'd2:  r = ia & ib;
            4'd3:  r = ia | ib;
            4'd4:  r = ia ^ ib;
            4'd5:  r = (ib >= 8) ? 0 : ia * (1 << ib);
            4'd6:  r = (ib >= 8) ? 0 : ia / (1 << ib);
            4'd7:  r = (ib >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> ib);
            4'd8:  r = ia * ib;
            4'd9:  r = (sa < sb) ? 1 : 0;
            4'd10: r = (ia < ib) ? 1 : 0;
            4'd11: r = ib;
            4'd12: r = 255 - ia;
            4'd13: begin
                r = 0 - ia;
                c = (ia == 0);
                v = (-sa > 127);
            end
            4'd14: r = (sa < sb) ? sa : sb;
            default: r = (sa < sb) ? sb : sa;
        endcase
        res = 8'(r & 255);
        return {res, (res == 8'h00), res[7], c, v};
    endfunction

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = {out, zero, negative, carry, overflow};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got out=%h zncv=%b, expected out=%h zncv=%b",
                     name, got[11:4], got[3:0], exp[11:4], exp[3:0]);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] va,
                         input logic [7:0] vb);
        operation = op;
        a = va;
        b = vb;
    endtask

    logic [11:0] pexp;
    logic        have;
    logic [3:0]  rop;
    logic [7:0]  ra, rb;
    logic [3:0]  pops[4];
    logic [7:0]  pa[4];
    logic [7:0]  pb[4];

    initial begin
        // name, op, a, b, out, {z,n,c,v}
        vt[0]  = '{"sub_03_01", 4'd1, 8'h03, 8'h01, 8'h02, 4'b0010};
        vt[1]  = '{"sub_fc_01", 4'd1, 8'hFC, 8'h01, 8'hFB, 4'b0110};
        vt[2]  = '{"sub_ff_01", 4'd1, 8'hFF, 8'h01, 8'hFE, 4'b0110};
        vt[3]  = '{"sub_81_01", 4'd1, 8'h81, 8'h01, 8'h80, 4'b0110};
        vt[4]  = '{"sub_03_81", 4'd1, 8'h03, 8'h81, 8'h82, 4'b0101};
        vt[5]  = '{"sub_80_01", 4'd1, 8'h80, 8'h01, 8'h7F, 4'b0011};
        vt[6]  = '{"add_7f_01", 4'd0, 8'h7F, 8'h01, 8'h80, 4'b0101};
        vt[7]  = '{"add_ff_01", 4'd0, 8'hFF, 8'h01, 8'h00, 4'b1010};
        vt[8]  = '{"and",       4'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000};
        vt[9]  = '{"xor",       4'd4, 8'hAA, 8'hFF, 8'h55, 4'b0000};
        vt[10] = '{"sll_7",     4'd5, 8'h01, 8'h07, 8'h80, 4'b0100};
        vt[11] = '{"srl_7",     4'd6, 8'h80, 8'h07, 8'h01, 4'b0000};
        vt[12] = '{"sra_3",     4'd7, 8'h80, 8'h03, 8'hF0, 4'b0100};
        vt[13] = '{"sra_9",     4'd7, 8'h80, 8'h09, 8'hFF, 4'b0100};
        vt[14] = '{"sll_8",     4'd5, 8'h01, 8'h08, 8'h00, 4'b1000};
        vt[15] = '{"slt",       4'd9, 8'h80, 8'h01, 8'h01, 4'b0000};
        vt[16] = '{"sltu",      4'd10, 8'h80, 8'h01, 8'h00, 4'b1000};
        vt[17] = '{"min",       4'd14, 8'h80, 8'h7F, 8'h80, 4'b0100};
        vt[18] = '{"max",       4'd15, 8'h80, 8'h7F, 8'h7F, 4'b0000};
        vt[19] = '{"mul",       4'd8, 8'h10, 8'h11, 8'h10, 4'b0000};
        vt[20] = '{"neg_01",    4'd13, 8'h01, 8'h00, 8'hFF, 4'b0100};
        vt[21] = '{"not_00",    4'd12, 8'h00, 8'h00, 8'hFF, 4'b0100};

        // Reset state, asynchronous, then first result after release.
        rst_n = 1'b1;
        drive(4'd0, 8'h55, 8'h0F);
        #2 rst_n = 1'b0;
        #1 check("reset_async", {8'h00, 4'b1000});
        repeat (2) @(posedge clk);
        #1 check("reset_held", {8'h00, 4'b1000});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("reset_release_add", {8'h64, 4'b0000});

        // Directed table.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(vt[i].op, vt[i].a, vt[i].b);
            @(posedge clk);
            #1 check(vt[i].name, {vt[i].eo, vt[i].ef});
        end

        // Back-to-back: each result exactly one edge after its inputs.
        pops[0] = 4'd0;  pa[0] = 8'h11; pb[0] = 8'h22;
        pops[1] = 4'd1;  pa[1] = 8'h10; pb[1] = 8'h20;
        pops[2] = 4'd3;  pa[2] = 8'h0C; pb[2] = 8'h40;
        pops[3] = 4'd11; pa[3] = 8'h00; pb[3] = 8'h5A;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k > 0)
                check($sformatf("pipe_%0d", k - 1),
                      model(pops[k-1], pa[k-1], pb[k-1]));
            if (k < 4)
                drive(pops[k], pa[k], pb[k]);
        end

        // Async reset mid-stream clears without a clock edge.
        @(negedge clk);
        drive(4'd0, 8'h7F, 8'h01);
        @(posedge clk);
        #1 check("pre_reset", {8'h80, 4'b0101});
        #2 rst_n = 1'b0;
        #1 check("mid_reset_async", {8'h00, 4'b1000});
        @(negedge clk);
        check("mid_reset_hold", {8'h00, 4'b1000});
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_reset", {8'h80, 4'b0101});

        // Random back-to-back vectors against the model.
        have = 1'b0;
        pexp = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (have) check("rand", pexp);
            rop = 4'($urandom_range(0, 15));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12))
                                              : 8'($urandom);
            drive(rop, ra, rb);
            pexp = model(rop, ra, rb);
            have = 1'b1;
        end
        @(negedge clk);
        check("rand_last", pexp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
